// File: rtl/ushift_burst_reg_if.sv
// Handshake/data bundle for ushift_burst_reg.
// master drives controls and data; slave returns q, serial taps, busy, done.
interface ushift_burst_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in_r;
  logic             ser_in_l;
  logic             start;
  logic [CNT_W-1:0] nshift;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, ser_in_r, ser_in_l,
    output start, nshift, dir,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, mode, d, ser_in_r, ser_in_l,
    input  start, nshift, dir,
    output q, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/ushift_burst_reg.sv
// Universal shift register (hold/shr/shl/load) with a burst shift engine.
// Ports: i_clock, i_reset (sync, active-high), bus (slave modport).
module ushift_burst_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  ushift_burst_reg_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

  assign w_shr = {bus.ser_in_r, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], bus.ser_in_l};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    if (bus.en) begin
      unique case (r_state)
        S_IDLE: begin
          // start takes priority over mode; q untouched on this edge
          if (bus.start) begin
            w_dir_nxt = bus.dir;
            if (bus.nshift != '0) begin
              w_cnt_nxt   = bus.nshift;
              w_state_nxt = S_SHIFT;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            unique case (bus.mode)
              2'b01:   w_q_nxt = w_shr;
              2'b10:   w_q_nxt = w_shl;
              2'b11:   w_q_nxt = bus.d;
              default: w_q_nxt = r_q;
            endcase
          end
        end
        S_SHIFT: begin
          w_q_nxt   = r_dir ? w_shl : w_shr;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.q      = r_q;
  assign bus.sout_r = r_q[0];
  assign bus.sout_l = r_q[WIDTH-1];
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);

endmodule

// File: tb/tb_ushift_burst_reg.sv
// Scoreboard bench for ushift_burst_reg: directed plan then random traffic.
// Model keeps a queue of pending burst steps instead of an explicit FSM.
module tb_ushift_burst_reg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ushift_burst_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  ushift_burst_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic         s_rst = 1'b1;
  logic         s_en = 1'b1;
  logic [1:0]   s_mode = 2'b00;
  logic [W-1:0] s_d = '0;
  logic         s_sr = 1'b0;
  logic         s_sl = 1'b0;
  logic         s_start = 1'b0;
  logic [CW-1:0] s_ns = '0;
  logic         s_dir = 1'b0;

  // model: register value plus queue of pending burst steps
  // step codes: 0 shift right, 1 shift left, 2 done cycle
  logic [W-1:0] m_q = '0;
  int           plan[$];
  logic [W+1:0] exp_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    int c;
    if (s_rst) begin
      m_q = '0;
      plan.delete();
    end else if (s_en) begin
      if (plan.size() == 0) begin
        if (s_start) begin
          for (int i = 0; i < int'(s_ns); i++) plan.push_back(s_dir ? 1 : 0);
          plan.push_back(2);
        end else begin
          case (s_mode)
            2'b01: m_q = {s_sr, m_q[W-1:1]};
            2'b10: m_q = {m_q[W-2:0], s_sl};
            2'b11: m_q = s_d;
            default: m_q = m_q;
          endcase
        end
      end else begin
        c = plan.pop_front();
        if (c == 0) m_q = {s_sr, m_q[W-1:1]};
        else if (c == 1) m_q = {m_q[W-2:0], s_sl};
      end
    end
    exp_q.push_back({m_q,
                     plan.size() > 0 && plan[0] != 2,
                     plan.size() > 0 && plan[0] == 2});
  endfunction

  task automatic tick();
    @(negedge clk);
    rst          = s_rst;
    bus.en       = s_en;
    bus.mode     = s_mode;
    bus.d        = s_d;
    bus.ser_in_r = s_sr;
    bus.ser_in_l = s_sl;
    bus.start    = s_start;
    bus.nshift   = s_ns;
    bus.dir      = s_dir;
    model_edge();
  endtask

  task automatic post(string nm, logic [W-1:0] eq,
                      logic eb, logic ed);
    @(posedge clk);
    #2;
    chk({nm, "_q"}, 32'(bus.q), 32'(eq));
    chk({nm, "_busy"}, 32'(bus.busy), 32'(eb));
    chk({nm, "_done"}, 32'(bus.done), 32'(ed));
  endtask

  initial begin
    logic [W+1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_q", 32'(bus.q), 32'(e[W+1:2]));
        chk("sb_busy", 32'(bus.busy), 32'(e[1]));
        chk("sb_done", 32'(bus.done), 32'(e[0]));
        chk("sb_sout_r", 32'(bus.sout_r), 32'(e[2]));
        chk("sb_sout_l", 32'(bus.sout_l), 32'(e[W+1]));
      end
    end
  end

  initial begin
    bus.en = 1'b1; bus.mode = 2'b00; bus.d = '0;
    bus.ser_in_r = 1'b0; bus.ser_in_l = 1'b0;
    bus.start = 1'b0; bus.nshift = '0; bus.dir = 1'b0;

    s_rst = 1'b1; s_mode = 2'b11; s_d = 8'hA5;
    tick(); tick(); post("reset", 8'h00, 1'b0, 1'b0);
    s_rst = 1'b0;

    tick(); post("load", 8'hA5, 1'b0, 1'b0);
    s_mode = 2'b01; s_sr = 1'b1;
    tick(); post("shr", 8'hD2, 1'b0, 1'b0);
    s_mode = 2'b10; s_sl = 1'b0;
    tick(); post("shl", 8'hA4, 1'b0, 1'b0);
    s_mode = 2'b00;
    tick(); post("hold", 8'hA4, 1'b0, 1'b0);
    chk("sout_r", 32'(bus.sout_r), 32'd0);
    chk("sout_l", 32'(bus.sout_l), 32'd1);

    s_mode = 2'b11; s_d = 8'h81;
    tick(); post("ld81", 8'h81, 1'b0, 1'b0);
    s_mode = 2'b00; s_start = 1'b1; s_ns = 4'd3; s_dir = 1'b1; s_sl = 1'b1;
    tick(); post("b_e0", 8'h81, 1'b1, 1'b0);
    s_start = 1'b0; s_mode = 2'b11; s_d = 8'hFF;
    tick(); post("b_e1", 8'h03, 1'b1, 1'b0);
    tick(); post("b_e2", 8'h07, 1'b1, 1'b0);
    tick(); post("b_e3", 8'h0F, 1'b0, 1'b1);
    s_mode = 2'b00;
    tick(); post("b_e4", 8'h0F, 1'b0, 1'b0);

    s_mode = 2'b11; s_d = 8'h81;
    tick(); post("ld81b", 8'h81, 1'b0, 1'b0);
    s_mode = 2'b00; s_start = 1'b1;
    tick(); post("f_e0", 8'h81, 1'b1, 1'b0);
    s_start = 1'b0;
    tick(); post("f_e1", 8'h03, 1'b1, 1'b0);
    s_en = 1'b0;
    tick(); post("f_frz1", 8'h03, 1'b1, 1'b0);
    tick(); post("f_frz2", 8'h03, 1'b1, 1'b0);
    s_en = 1'b1;
    tick(); post("f_e2", 8'h07, 1'b1, 1'b0);
    tick(); post("f_e3", 8'h0F, 1'b0, 1'b1);
    s_en = 1'b0;
    tick(); post("f_stretch", 8'h0F, 1'b0, 1'b1);
    s_en = 1'b1;
    tick(); post("f_idle", 8'h0F, 1'b0, 1'b0);

    s_start = 1'b1; s_ns = 4'd0;
    tick(); post("z_done", 8'h0F, 1'b0, 1'b1);
    s_ns = 4'd2;
    tick(); post("z_ign", 8'h0F, 1'b0, 1'b0);
    s_start = 1'b0;
    tick(); post("z_idle", 8'h0F, 1'b0, 1'b0);

    s_start = 1'b1; s_ns = 4'd5; s_dir = 1'b0; s_sr = 1'b1;
    tick(); post("r_e0", 8'h0F, 1'b1, 1'b0);
    s_start = 1'b0;
    tick(); post("r_e1", 8'h87, 1'b1, 1'b0);
    tick(); post("r_e2", 8'hC3, 1'b1, 1'b0);
    s_rst = 1'b1;
    tick(); post("r_rst", 8'h00, 1'b0, 1'b0);
    s_rst = 1'b0;
    tick(); post("r_nd1", 8'h00, 1'b0, 1'b0);
    tick(); post("r_nd2", 8'h00, 1'b0, 1'b0);
    s_start = 1'b1; s_ns = 4'd2;
    tick(); post("r2_e0", 8'h00, 1'b1, 1'b0);
    s_start = 1'b0;
    tick(); post("r2_e1", 8'h80, 1'b1, 1'b0);
    tick(); post("r2_e2", 8'hC0, 1'b0, 1'b1);
    tick(); post("r2_e3", 8'hC0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom % 100) == 0;
      s_en    = ($urandom % 8) != 0;
      s_mode  = 2'($urandom);
      s_d     = W'($urandom);
      s_sr    = 1'($urandom);
      s_sl    = 1'($urandom);
      s_start = ($urandom % 4) == 0;
      s_ns    = CW'($urandom);
      s_dir   = 1'($urandom);
      tick();
    end
    s_rst = 1'b0; s_start = 1'b0; s_mode = 2'b00; s_en = 1'b1;
    tick();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
